// File: rtl/control_pkg.sv
// control_pkg: RV32I opcode, ALU, immediate, next-PC and operand-A encodings for the main decoder
package control_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_ADD4 = 4'b1011;
  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_BJ = 2'b10;
  localparam logic [1:0] IMM_U  = 2'b11;
  localparam logic [1:0] NS_PC4    = 2'b00;
  localparam logic [1:0] NS_BRANCH = 2'b01;
  localparam logic [1:0] NS_JAL    = 2'b10;
  localparam logic [1:0] NS_JALR   = 2'b11;
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;
  typedef enum logic [2:0] {CLS_ADD, CLS_ADD4, CLS_R, CLS_I, CLS_BR} alu_cls_e;
  typedef struct packed {
    logic       reg_write;
    logic       branch;
    logic       store;
    logic       load;
    logic       mem_reg;
    logic       opB;
    logic [1:0] imm_sel;
    logic [1:0] next_sel;
    logic [1:0] opA;
  } ctrl_t;
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps opcode class, func3 and func7 to the ALU operation and flags unsupported ALU encodings
module alu_decoder
  import control_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic [3:0] alu_c,
  output logic       illegal_alu
);
  always_comb begin
    alu_c = ALU_ADD;
    illegal_alu = 1'b0;
    case (cls)
      CLS_ADD4: alu_c = ALU_ADD4;
      CLS_R: begin
        alu_c = (func3 == 3'b000 && func7) ? ALU_SUB :
                (func3 == 3'b101 && func7) ? ALU_SRA : base_alu(func3);
        illegal_alu = func7 && func3 != 3'b000 && func3 != 3'b101;
      end
      CLS_I: begin
        alu_c = (func3 == 3'b101 && func7) ? ALU_SRA : base_alu(func3);
        illegal_alu = func7 && func3 == 3'b001;
      end
      CLS_BR: begin
        alu_c = func3[2] ? (func3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        illegal_alu = func3[2:1] == 2'b01;
      end
      default: alu_c = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder producing datapath controls plus a sticky illegal-encoding flag
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic       reg_write,
  output logic       branch,
  output logic       store,
  output logic       load,
  output logic       mem_reg,
  output logic       opB,
  output logic [1:0] imm_sel,
  output logic [1:0] next_sel,
  output logic [1:0] opA,
  output logic [3:0] ALU_C,
  output logic       illegal,
  output logic       illegal_seen
);
  ctrl_t      c;
  ctrl_t      c_out;
  alu_cls_e   cls;
  logic       bad;
  logic       illegal_alu;
  logic [3:0] alu_c;
  logic       illegal_seen_d;
  logic       illegal_seen_q;
  alu_decoder u_alu_dec (
    .cls         (cls),
    .func3       (func3),
    .func7       (func7),
    .alu_c       (alu_c),
    .illegal_alu (illegal_alu)
  );
  always_comb begin
    c = '0;
    cls = CLS_ADD;
    bad = 1'b0;
    case (opcode)
      OP_R: begin
        c.reg_write = 1'b1;
        cls = CLS_R;
      end
      OP_I: begin
        c.reg_write = 1'b1;
        c.opB = 1'b1;
        cls = CLS_I;
      end
      OP_LOAD: begin
        c.reg_write = 1'b1;
        c.load = 1'b1;
        c.mem_reg = 1'b1;
        c.opB = 1'b1;
        bad = func3 == 3'b011 || func3[2:1] == 2'b11;
      end
      OP_STORE: begin
        c.store = 1'b1;
        c.opB = 1'b1;
        c.imm_sel = IMM_S;
        bad = func3 >= 3'b011;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.next_sel = NS_BRANCH;
        c.imm_sel = IMM_BJ;
        cls = CLS_BR;
      end
      OP_JAL: begin
        c.reg_write = 1'b1;
        c.next_sel = NS_JAL;
        c.imm_sel = IMM_BJ;
        c.opA = OPA_PC;
        cls = CLS_ADD4;
      end
      OP_JALR: begin
        c.reg_write = 1'b1;
        c.next_sel = NS_JALR;
        c.opA = OPA_PC;
        cls = CLS_ADD4;
        bad = func3 != 3'b000;
      end
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.opA = OPA_ZERO;
        c.opB = 1'b1;
        c.imm_sel = IMM_U;
      end
      OP_AUIPC: begin
        c.reg_write = 1'b1;
        c.opA = OPA_PC;
        c.opB = 1'b1;
        c.imm_sel = IMM_U;
      end
      default: bad = 1'b1;
    endcase
  end
  assign illegal = bad | illegal_alu;
  assign c_out = illegal ? '0 : c;
  assign {reg_write, branch, store, load, mem_reg, opB, imm_sel, next_sel, opA} = c_out;
  assign ALU_C = illegal ? ALU_ADD : alu_c;
  always_comb illegal_seen_d = illegal_seen_q | illegal;
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_seen_q <= 1'b0;
    else        illegal_seen_q <= illegal_seen_d;
  end
  assign illegal_seen = illegal_seen_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector check of the RV32I main decoder and its sticky illegal flag
module tb_control_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7;
  logic       reg_write, branch, store, load, mem_reg, opB, illegal, illegal_seen;
  logic [1:0] imm_sel, next_sel, opA;
  logic [3:0] ALU_C;
  int         n_run = 0;
  int         n_fail = 0;
  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .reg_write    (reg_write),
    .branch       (branch),
    .store        (store),
    .load         (load),
    .mem_reg      (mem_reg),
    .opB          (opB),
    .imm_sel      (imm_sel),
    .next_sel     (next_sel),
    .opA          (opA),
    .ALU_C        (ALU_C),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] pk(input logic rw, br, st, ld, mr, ob,
                                     input logic [1:0] imm, ns, opa,
                                     input logic [3:0] alu, input logic ill);
    return {rw, br, st, ld, mr, ob, imm, ns, opa, alu, ill};
  endfunction
  wire [16:0] ctrl = {reg_write, branch, store, load, mem_reg, opB, imm_sel, next_sel, opA, ALU_C, illegal};
  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    @(negedge clk);
    opcode = op;
    func3 = f3;
    func7 = f7;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  localparam logic [16:0] NOP_ILL = 17'b0000_0000_0000_0000_1;
  initial begin
    rst_n = 1'b0;
    opcode = 7'b0110111;
    func3 = 3'b000;
    func7 = 1'b0;
    repeat (2) tick();
    chk("rst_seen", {16'b0, illegal_seen}, 17'd0);
    rst_n = 1'b1;
    tick();
    chk("seen_legal", {16'b0, illegal_seen}, 17'd0);
    apply(7'b0100001, 3'b001, 1'b0);
    chk("bad_opcode", ctrl, NOP_ILL);
    chk("seen_pre_edge", {16'b0, illegal_seen}, 17'd0);
    tick();
    chk("seen_set", {16'b0, illegal_seen}, 17'd1);
    apply(7'b0110111, 3'b000, 1'b0);
    tick();
    chk("seen_sticky", {16'b0, illegal_seen}, 17'd1);
    chk("lui", ctrl, pk(1,0,0,0,0,1,2'b11,2'b00,2'b10,4'b0000,0));
    apply(7'b0010111, 3'b101, 1'b1);
    chk("auipc", ctrl, pk(1,0,0,0,0,1,2'b11,2'b00,2'b01,4'b0000,0));
    apply(7'b0000011, 3'b010, 1'b0);
    chk("lw", ctrl, pk(1,0,0,1,1,1,2'b00,2'b00,2'b00,4'b0000,0));
    apply(7'b0000011, 3'b111, 1'b0);
    chk("load_f3_111", ctrl, NOP_ILL);
    apply(7'b0000011, 3'b011, 1'b0);
    chk("load_f3_011", ctrl, NOP_ILL);
    apply(7'b0000011, 3'b101, 1'b1);
    chk("lhu", ctrl, pk(1,0,0,1,1,1,2'b00,2'b00,2'b00,4'b0000,0));
    apply(7'b0100011, 3'b010, 1'b0);
    chk("sw", ctrl, pk(0,0,1,0,0,1,2'b01,2'b00,2'b00,4'b0000,0));
    apply(7'b0100011, 3'b011, 1'b0);
    chk("store_f3_011", ctrl, NOP_ILL);
    apply(7'b0110011, 3'b000, 1'b1);
    chk("sub", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0001,0));
    apply(7'b0110011, 3'b000, 1'b0);
    chk("add", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0000,0));
    apply(7'b0110011, 3'b101, 1'b1);
    chk("sra", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0111,0));
    apply(7'b0110011, 3'b101, 1'b0);
    chk("srl", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0110,0));
    apply(7'b0110011, 3'b010, 1'b0);
    chk("slt", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0011,0));
    apply(7'b0110011, 3'b100, 1'b0);
    chk("xor", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0101,0));
    apply(7'b0110011, 3'b110, 1'b0);
    chk("or", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b1000,0));
    apply(7'b0110011, 3'b111, 1'b0);
    chk("and", ctrl, pk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b1001,0));
    apply(7'b0110011, 3'b111, 1'b1);
    chk("r_and_f7", ctrl, NOP_ILL);
    apply(7'b0010011, 3'b000, 1'b1);
    chk("addi_f7", ctrl, pk(1,0,0,0,0,1,2'b00,2'b00,2'b00,4'b0000,0));
    apply(7'b0010011, 3'b001, 1'b0);
    chk("slli", ctrl, pk(1,0,0,0,0,1,2'b00,2'b00,2'b00,4'b0010,0));
    apply(7'b0010011, 3'b001, 1'b1);
    chk("slli_f7", ctrl, NOP_ILL);
    apply(7'b0010011, 3'b101, 1'b1);
    chk("srai", ctrl, pk(1,0,0,0,0,1,2'b00,2'b00,2'b00,4'b0111,0));
    apply(7'b0010011, 3'b011, 1'b1);
    chk("sltiu_f7", ctrl, pk(1,0,0,0,0,1,2'b00,2'b00,2'b00,4'b0100,0));
    apply(7'b1100011, 3'b110, 1'b0);
    chk("bltu", ctrl, pk(0,1,0,0,0,0,2'b10,2'b01,2'b00,4'b0100,0));
    apply(7'b1100011, 3'b001, 1'b1);
    chk("bne", ctrl, pk(0,1,0,0,0,0,2'b10,2'b01,2'b00,4'b0001,0));
    apply(7'b1100011, 3'b101, 1'b0);
    chk("bge", ctrl, pk(0,1,0,0,0,0,2'b10,2'b01,2'b00,4'b0011,0));
    apply(7'b1100011, 3'b010, 1'b0);
    chk("branch_f3_010", ctrl, NOP_ILL);
    apply(7'b1101111, 3'b011, 1'b1);
    chk("jal", ctrl, pk(1,0,0,0,0,0,2'b10,2'b10,2'b01,4'b1011,0));
    apply(7'b1100111, 3'b000, 1'b0);
    chk("jalr", ctrl, pk(1,0,0,0,0,0,2'b00,2'b11,2'b01,4'b1011,0));
    apply(7'b1100111, 3'b001, 1'b0);
    chk("jalr_f3_001", ctrl, NOP_ILL);
    apply(7'b0000000, 3'b000, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rst_over_set", {16'b0, illegal_seen}, 17'd0);
    rst_n = 1'b1;
    tick();
    chk("reset_release_set", {16'b0, illegal_seen}, 17'd1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
